dec38_hold_queue: RTL and testbench
===================================

# dec38_hold_queue

Sequential 3-to-8 decoder that receives 3-bit codes with a valid indicator from the priority-encoder stage. It queues them in a small FIFO and drives each as a one-hot 8-bit pattern for a fixed number of cycles. It is the decode end of the encoder path: encoder output (code + "any input active" flag) in, one-hot LED/select lines out. Back-to-back codes are shown without gaps; empty-flag entries are discarded.

## Interface
- `HOLD`, default 4: cycles each one-hot pattern is held; legal range 1..255.
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  offer of one code this cycle.
- `in_code`  in  3  code to decode, 0..7.
- `in_idc`  in  1  encoder "input present" flag; 0 means the entry carries no code.
- `in_ready`  out  1  block can accept; equals !full.
- `y`  out  8  registered one-hot output; all zero when idle.
- `active`  out  1  high while a pattern is driven (state SHOW).
- `level`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready.
  - If in_idc=1, in_code is pushed.
  - If in_idc=0, the transfer completes but nothing is stored and level is unchanged.
- in_ready depends only on the registered full flag. A pop in the same cycle does not raise in_ready. No combinational path from in_valid to in_ready.
- FIFO: read/write pointers one bit wider than log2(DEPTH), wrapping modulo 2·DEPTH.
  - full when the pointers differ only in the MSB; empty when equal.
  - Simultaneous push and pop both take effect and leave level unchanged. This is allowed when empty only if the push is from a prior cycle; a same-cycle push is not visible to pop.
- State machine, 2 states:
  - IDLE: y=0, active=0. If the FIFO is non-empty: pop the head, y ← 1<<code, hold counter ← HOLD-1, go to SHOW.
  - SHOW: y held, active=1. If counter≠0: counter−1. If counter=0 and FIFO non-empty: pop, load the new one-hot, counter ← HOLD-1, stay in SHOW (no gap cycle). If counter=0 and FIFO empty: y ← 0, go to IDLE.
- Counter width is 8 bits, and it never underflows.
- Reset (asserted at any time, including mid-SHOW or mid-push): state=IDLE, y=8'h00, active=0, pointers=0, level=0, counter=0, in_ready=1 once rst_n deasserts. Queued entries are lost.

## Timing
- Latency: a code pushed at edge N into an empty FIFO while IDLE appears on y after edge N+1.
- Each pattern is visible for exactly HOLD consecutive cycles.
- Consecutive queued codes appear on consecutive HOLD windows with no all-zero cycle between them.
- After the last pattern, y returns to 0 one cycle after its HOLD window ends.
- HOLD=1: one cycle per code; throughput is one code per cycle when the FIFO is fed continuously.
- Full FIFO (level=DEPTH): in_ready=0; in_valid is ignored and in_code/in_idc are not sampled. in_ready returns high the cycle after a pop.
- All outputs are registered. y is always zero-hot or exactly one-hot; a glitch-free one-hot is checked by an assertion each cycle.

## Test plan
- Reset mid-operation. Stimulus: assert rst_n=0 asynchronously mid-SHOW with level=2. Required: y=0, active=0, level=0 immediately; after release, in_ready=1 and nothing is displayed.
- Single code. Stimulus: HOLD=4, push code 5 at edge 0 from IDLE. Required: y=8'h20 during cycles 1–4, y=0 from cycle 5, active mirrors this.
- Back-to-back codes. Stimulus: HOLD=2, push codes 0, 7, 3 on consecutive edges. Required: y=01,01,80,80,08,08, then 00, with no zero cycle between patterns.
- Full FIFO. Stimulus: DEPTH=4, hold the display busy and push 5 codes with in_valid held high. Required: the 5th is stalled with in_ready=0 and level=4 until the first pop; all 5 patterns are shown in order.
- Empty-flag entries. Stimulus: push with in_idc=0 and in_code=6. Required: handshake completes, level stays 0, y stays 0. Then a push with in_idc=1 and code 6 yields y=8'h40.
- HOLD=1 streaming. Stimulus: push codes 0..7 on every cycle. Required: y walks 01,02,…,80 on consecutive cycles with in_ready never deasserted.

Source files
------------

// File: rtl/dec38_hold_queue.sv
// ---------------------------------------------------------------------------
// dec38_hold_queue
//
// Decode end of the priority-encoder path. Codes arriving from the encoder
// (3-bit code plus an "input present" flag) are queued in a small FIFO and
// each one is shown as a one-hot 8-bit pattern for HOLD consecutive cycles.
// Queued codes follow each other with no blank cycle in between. Offers
// whose flag is low are accepted but not stored.
//
// Parameters
//   HOLD      cycles each one-hot pattern stays on y (1..255)
//   DEPTH     FIFO entries, power of two, >= 2
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  offer of one code this cycle
//   in_code   code to decode (0..7)
//   in_idc    encoder "input present" flag; 0 = entry carries no code
//   in_ready  block can accept (registered, equals !full)
//   y         registered one-hot pattern, all zero when idle
//   active    high while a pattern is being driven
//   level     current FIFO occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module dec38_hold_queue #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  input  logic                     in_idc,
  output logic                     in_ready,
  output logic [7:0]               y,
  output logic                     active,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // one-hot decode of a 3-bit code
  function automatic logic [7:0] onehot(input logic [2:0] code);
    logic [7:0] r;
    r = 8'h00;
    r[code] = 1'b1;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  logic [2:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        empty;
  logic        push;
  logic        pop;
  logic [2:0]  head;

  // in_ready comes straight from the registered full flag, so a pop in
  // the current cycle cannot raise it and in_valid never reaches it.
  assign push  = in_valid && !full_q && in_idc;
  // empty is judged on registered pointers: a push on this edge is not
  // yet visible to the pop logic.
  assign empty = (wptr_q == rptr_q);
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  // Occupancy is the pointer difference modulo 2*DEPTH; full when the
  // pointers agree in the index bits but differ in the wrap bit.
  always_comb begin
    level_d = wptr_d - rptr_d;
    full_d  = (wptr_d[AW] != rptr_d[AW]) &&
              (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

  // Entry storage carries data only; no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_code;
  end

  // -------------------------------------------------------------------------
  // Display state machine
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        active_q, active_d;

  // state register (plus the registered outputs it drives)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      y_q      <= 8'h00;
      cnt_q    <= 8'h00;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = SHOW;
      SHOW:    if ((cnt_q == 8'h00) && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output / datapath logic
  always_comb begin
    pop   = 1'b0;
    y_d   = y_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          y_d   = onehot(head);
          cnt_d = HOLD_M1;
        end else begin
          y_d   = 8'h00;
          cnt_d = 8'h00;
        end
      end
      SHOW: begin
        if (cnt_q != 8'h00) begin
          cnt_d = cnt_q - 8'h01;
        end else if (!empty) begin
          // window ended with work waiting: reload without a blank cycle
          pop   = 1'b1;
          y_d   = onehot(head);
          cnt_d = HOLD_M1;
        end else begin
          y_d   = 8'h00;
        end
      end
      default: begin
        y_d   = 8'h00;
        cnt_d = 8'h00;
      end
    endcase
    active_d = (state_d == SHOW);
  end

  assign in_ready = !full_q;
  assign y        = y_q;
  assign active   = active_q;
  assign level    = level_q;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(y_q));
  a_active_y : assert property (@(posedge clk) disable iff (!rst_n)
    active_q == (y_q != 8'h00));
  a_level_max : assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_dec38_hold_queue.sv
// ---------------------------------------------------------------------------
// tb_dec38_hold_queue
//
// Three instances (HOLD = 4, 2, 1; DEPTH = 4) share one stimulus stream.
// A posedge sampler records every accepted, flagged code with the edge it
// was taken on; a negedge monitor pops those codes according to the hold
// rules and compares y / active / level / in_ready of each instance.
// ---------------------------------------------------------------------------
module tb_dec38_hold_queue;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  typedef struct {
    int code;
    int t;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_idc = 1'b0;

  logic       in_ready_a [N];
  logic [7:0] y_a        [N];
  logic       active_a   [N];
  logic [2:0] level_a    [N];

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  ent_t exp_q [N][$];
  int   cur   [N] = '{-1, -1, -1};
  int   rem   [N] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dec38_hold_queue #(
      .HOLD  (g == 0 ? 4 : (g == 1 ? 2 : 1)),
      .DEPTH (DEPTH)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_code  (in_code),
      .in_idc   (in_idc),
      .in_ready (in_ready_a[g]),
      .y        (y_a[g]),
      .active   (active_a[g]),
      .level    (level_a[g])
    );
  end

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s dut%0d edge=%0d got=%0d expected=%0d", nm, i, cyc, act, exp);
    end
  endtask

  // Sampler: record accepted codes. Ready is judged from the occupancy the
  // model held before this edge (a same-edge pop does not raise ready).
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (in_valid && in_idc && (exp_q[i].size() < DEPTH))
            exp_q[i].push_back('{int'(in_code), cyc});
        end
      end
    end
  end

  // Monitor: advance each display model by one edge and compare.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int i = 0; i < N; i++) begin
          chk("rst_y",     i, int'(y_a[i]),      0);
          chk("rst_active", i, int'(active_a[i]), 0);
          chk("rst_level", i, int'(level_a[i]),  0);
          exp_q[i].delete();
          cur[i] = -1;
          rem[i] = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          int ey;
          if (cur[i] >= 0 && rem[i] > 1) begin
            rem[i]--;
          end else if (exp_q[i].size() > 0 && exp_q[i][0].t < cyc) begin
            cur[i] = exp_q[i][0].code;
            rem[i] = hold_of(i);
            void'(exp_q[i].pop_front());
          end else begin
            cur[i] = -1;
          end
          ey = (cur[i] >= 0) ? (1 << cur[i]) : 0;
          chk("y",        i, int'(y_a[i]),        ey);
          chk("active",   i, int'(active_a[i]),   (cur[i] >= 0) ? 1 : 0);
          chk("level",    i, int'(level_a[i]),    exp_q[i].size());
          chk("in_ready", i, int'(in_ready_a[i]), (exp_q[i].size() < DEPTH) ? 1 : 0);
        end
      end
    end
  end

  // one cycle of stimulus, inputs change 1 time unit after the edge
  task automatic drive(input logic v, input int code, input logic idc);
    in_valid = v;
    in_code  = 3'(code);
    in_idc   = idc;
    @(posedge clk);
    #1;
  endtask

  // hold an offer until instance 0 (the slowest display) takes it
  task automatic push_hold(input int code);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'(code);
    in_idc   = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(posedge clk);
      if (in_ready_a[0]) done = 1'b1;
    end
    #1;
    if (!done) begin
      miss++;
      $display("FAIL stall_timeout dut0 code=%0d got=no_accept expected=accept", code);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0);
  endtask

  initial begin
    // reset from time zero
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // single code 5
    drive(1'b1, 5, 1'b1);
    idle(8);

    // back-to-back codes 0, 7, 3
    drive(1'b1, 0, 1'b1);
    drive(1'b1, 7, 1'b1);
    drive(1'b1, 3, 1'b1);
    idle(16);

    // fill the FIFO behind a busy display, in_valid held high throughout
    for (int c = 1; c <= 6; c++) push_hold(c);
    in_valid = 1'b0;
    idle(32);

    // empty-flag entry, then the real code 6
    drive(1'b1, 6, 1'b0);
    idle(3);
    drive(1'b1, 6, 1'b1);
    idle(8);

    // continuous stream 0..7
    for (int c = 0; c < 8; c++) drive(1'b1, c, 1'b1);
    idle(40);

    // reset mid-SHOW with two codes queued behind the display
    push_hold(2);
    push_hold(4);
    push_hold(1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            ($urandom_range(0, 4) != 0));
    end
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
